// File: rtl/ds_pkg.sv
// Shared types and helpers for the ds interconnect arbiter slice.
package ds_pkg;

  // Arbiter FSM encoding.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } t_arb_state;

  // Ceiling log2 with a floor of 1 so select/count fields are never zero-width.
  function automatic int unsigned sclog2(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage : ds_pkg

// File: rtl/ds_icon_arb_if.sv
// Request/grant bundle between the slave-side lanes and the arbiter.
interface ds_icon_arb_if
  import ds_pkg::*;
#(
  parameter int unsigned REQ_CNT = 4
);

  localparam int unsigned SEL_WIDTH = sclog2(REQ_CNT);

  logic [REQ_CNT-1:0]   req;
  logic                 hs;
  logic                 gnt_vld;
  logic [REQ_CNT-1:0]   gnt;
  logic [SEL_WIDTH-1:0] sel;

  // Arbiter side: consumes requests and handshakes, produces the grant.
  modport master (
    input  req,
    input  hs,
    output gnt_vld,
    output gnt,
    output sel
  );

  // Lane side: raises requests and observes the grant.
  modport slave (
    output req,
    output hs,
    input  gnt_vld,
    input  gnt,
    input  sel
  );

endinterface : ds_icon_arb_if

// File: rtl/ds_rr_pick.sv
// Combinational rotating-priority pick: first set req bit at ptr, ptr+1, ... wrapping.
module ds_rr_pick #(
  parameter int unsigned REQ_CNT   = 4,
  parameter int unsigned SEL_WIDTH = 2
) (
  input  logic [REQ_CNT-1:0]   req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 vld,
  output logic [SEL_WIDTH-1:0] idx
);

  int unsigned j;

  // Scan every lane once starting at ptr; the first hit wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    j   = 0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      j = (32'(ptr) + i) % REQ_CNT;
      if (!vld && req[j]) begin
        vld = 1'b1;
        idx = SEL_WIDTH'(j);
      end
    end
  end

endmodule : ds_rr_pick

// File: rtl/ds_icon_arb.sv
// Round-robin burst arbiter granting one slave lane ownership of the shared middle lane.
module ds_icon_arb
  import ds_pkg::*;
#(
  parameter int unsigned REQ_CNT   = 4,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [REQ_CNT-1:0]                i_req,
  input  logic                              i_hs,
  output logic                              o_gnt_vld,
  output logic [REQ_CNT-1:0]                o_gnt,
  output logic [sclog2(REQ_CNT)-1:0]        o_sel
);

  localparam int unsigned SEL_WIDTH = sclog2(REQ_CNT);
  localparam int unsigned CNT_WIDTH = sclog2(BURST_MAX + 1);

  // Reject illegal parameterisations at elaboration.
  if (BURST_MAX < 1) begin : g_bad_burst
    $error("ds_icon_arb: BURST_MAX must be >= 1");
  end
  if (REQ_CNT < 2 || REQ_CNT > 64) begin : g_bad_req
    $error("ds_icon_arb: REQ_CNT must be in 2..64");
  end

  t_arb_state           state, state_d;
  logic [SEL_WIDTH-1:0] ptr, ptr_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic                 gnt_vld_d;
  logic [REQ_CNT-1:0]   gnt_d;
  logic [SEL_WIDTH-1:0] sel_d;

  logic                 rel_c;
  logic [SEL_WIDTH-1:0] ptr_rel_c;
  logic [SEL_WIDTH-1:0] pick_ptr_c;
  logic                 pick_vld_c;
  logic [SEL_WIDTH-1:0] pick_idx_c;

  // Release condition and the rotated pointer it would install.
  always_comb begin
    rel_c      = 1'b0;
    ptr_rel_c  = (o_sel == SEL_WIDTH'(REQ_CNT - 1)) ? '0 : o_sel + SEL_WIDTH'(1);
    if (state == GRANT) begin
      rel_c = (i_hs && (cnt == CNT_WIDTH'(BURST_MAX - 1))) || (!i_req[o_sel] && !i_hs);
    end
    pick_ptr_c = rel_c ? ptr_rel_c : ptr;
  end

  ds_rr_pick #(
    .REQ_CNT   (REQ_CNT),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req (i_req),
    .ptr (pick_ptr_c),
    .vld (pick_vld_c),
    .idx (pick_idx_c)
  );

  // Next-state and next-output logic; a release re-arbitrates in the same cycle.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    cnt_d     = cnt;
    gnt_vld_d = o_gnt_vld;
    gnt_d     = o_gnt;
    sel_d     = o_sel;
    case (state)
      IDLE: begin
        if (pick_vld_c) begin
          state_d   = GRANT;
          cnt_d     = '0;
          gnt_vld_d = 1'b1;
          sel_d     = pick_idx_c;
          gnt_d     = REQ_CNT'(1) << pick_idx_c;
        end
      end
      GRANT: begin
        if (i_hs) begin
          cnt_d = cnt + CNT_WIDTH'(1);
        end
        if (rel_c) begin
          ptr_d = ptr_rel_c;
          cnt_d = '0;
          if (pick_vld_c) begin
            sel_d = pick_idx_c;
            gnt_d = REQ_CNT'(1) << pick_idx_c;
          end else begin
            state_d   = IDLE;
            gnt_vld_d = 1'b0;
            gnt_d     = '0;
            sel_d     = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        gnt_vld_d = 1'b0;
        gnt_d     = '0;
        sel_d     = '0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      o_gnt_vld <= 1'b0;
      o_gnt     <= '0;
      o_sel     <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      o_gnt_vld <= gnt_vld_d;
      o_gnt     <= gnt_d;
      o_sel     <= sel_d;
    end
  end

endmodule : ds_icon_arb

// File: tb/tb_ds_icon_arb.sv
// Scoreboard bench for ds_icon_arb: directed vectors plus a random invariant/starvation run.
module tb_ds_icon_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned BM = 4;

  typedef struct {
    int         tag;
    logic       vld;
    logic [3:0] gnt;
    logic [1:0] sel;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   tag_n;
  bit   rnd_on;
  int   wait_hs [N];
  exp_t exp_q [$];

  ds_icon_arb_if #(.REQ_CNT(N)) bus ();

  ds_icon_arb #(
    .REQ_CNT   (N),
    .BURST_MAX (BM)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_req     (bus.req),
    .i_hs      (bus.hs),
    .o_gnt_vld (bus.gnt_vld),
    .o_gnt     (bus.gnt),
    .o_sel     (bus.sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic hs,
                     input logic ev, input logic [1:0] es);
    exp_t e;
    rst_n   = rst;
    bus.req = req;
    bus.hs  = hs;
    @(posedge clk);
    #1;
    e.tag = tag_n;
    e.vld = ev;
    e.sel = ev ? es : 2'd0;
    e.gnt = ev ? (4'b0001 << es) : 4'b0000;
    tag_n++;
    exp_q.push_back(e);
  endtask

  // Monitor: compare queued expectations and, in the random phase, check invariants.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] oh;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (bus.gnt_vld !== e.vld || bus.gnt !== e.gnt || bus.sel !== e.sel) begin
        bad++;
        $display("FAIL step%0d: got vld=%b gnt=%b sel=%0d, want vld=%b gnt=%b sel=%0d",
                 e.tag, bus.gnt_vld, bus.gnt, bus.sel, e.vld, e.gnt, e.sel);
      end
    end
    if (rnd_on) begin
      oh = bus.gnt_vld ? (4'b0001 << bus.sel) : 4'b0000;
      total++;
      if (bus.gnt !== oh) begin
        bad++;
        $display("FAIL rnd_onehot t=%0t: got gnt=%b vld=%b sel=%0d, want gnt=%b",
                 $time, bus.gnt, bus.gnt_vld, bus.sel, oh);
      end
      for (int i = 0; i < int'(N); i++) begin
        if (bus.gnt[i] || !bus.req[i]) begin
          wait_hs[i] = 0;
        end else if (bus.gnt_vld && bus.hs) begin
          wait_hs[i] = wait_hs[i] + 1;
        end
        total++;
        if (wait_hs[i] > int'((N - 1) * BM)) begin
          bad++;
          $display("FAIL rnd_starve lane%0d t=%0t: waited %0d handshakes, limit %0d",
                   i, $time, wait_hs[i], (N - 1) * BM);
          wait_hs[i] = 0;
        end
      end
    end
  end

  initial begin
    logic [3:0] rq;
    total   = 0;
    bad     = 0;
    tag_n   = 0;
    rnd_on  = 1'b0;
    rst_n   = 1'b0;
    bus.req = '0;
    bus.hs  = 1'b0;
    for (int i = 0; i < int'(N); i++) wait_hs[i] = 0;

    // Reset state, then idle with no requests.
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    cyc(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);

    // All lanes requesting with a handshake every cycle: 0,1,2,3,0 for 4 cycles each.
    for (int g = 0; g < 5; g++)
      for (int k = 0; k < 4; k++)
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 2'(g % 4));
    // Lane 0 drops with no handshake: release to IDLE, ptr=1.
    cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Single request on lane 2, held, then dropped: IDLE with ptr=3.
    cyc(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2);
    cyc(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2);
    cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    // ptr=3 is visible as lane 3 winning a full request set.
    cyc(1'b1, 4'b1111, 1'b0, 1'b1, 2'd3);

    // Lane 3 drops, lane 1 wins; held 10 cycles with no handshake despite other requests.
    cyc(1'b1, 4'b0010, 1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'b1111, 1'b0, 1'b1, 2'd1);

    // Last word: handshake with request dropped keeps the grant, then release to lane 2.
    cyc(1'b1, 4'b1101, 1'b1, 1'b1, 2'd1);
    cyc(1'b1, 4'b1101, 1'b0, 1'b1, 2'd2);

    // Two handshakes on lane 2 (cnt=2), then reset mid-burst drops the grant.
    cyc(1'b1, 4'b1111, 1'b1, 1'b1, 2'd2);
    cyc(1'b1, 4'b1111, 1'b1, 1'b1, 2'd2);
    cyc(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
    cyc(1'b1, 4'b1000, 1'b0, 1'b1, 2'd3);
    cyc(1'b1, 4'b1000, 1'b0, 1'b1, 2'd3);
    cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Handshakes in IDLE are ignored; a fresh burst still lasts 4 handshakes.
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 4'b1111, 1'b1, 1'b1, 2'd0);
    cyc(1'b1, 4'b1111, 1'b1, 1'b1, 2'd1);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    // Random requests and handshakes with slowly changing request patterns.
    rst_n   = 1'b1;
    rq      = 4'($urandom_range(0, 15));
    bus.req = rq;
    bus.hs  = 1'b0;
    @(posedge clk);
    #1;
    rnd_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < int'(N); i++)
        if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
      bus.req = rq;
      bus.hs  = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rnd_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ds_icon_arb
